// File: rtl/sc_sync_pkg.sv
// Shared types and helpers for the stochastic-stream pair correlation manipulator.
package sc_sync_pkg;

  typedef enum logic [1:0] {
    MODE_SYNC   = 2'd0,
    MODE_DESYNC = 2'd1,
    MODE_SKEW   = 2'd2,
    MODE_BYPASS = 2'd3
  } sync_mode_e;

  function automatic int unsigned save_max(int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_pair_sync_multi_if.sv
// Handshake/data bundle between a stream source and the pair correlation manipulator.
interface sc_pair_sync_multi_if
  import sc_sync_pkg::*;
#(
  parameter int unsigned LANES = 4
);
  logic             en;
  logic             clr;
  sync_mode_e       mode;
  logic [LANES-1:0] in_a;
  logic [LANES-1:0] in_b;
  logic [LANES-1:0] out_a;
  logic [LANES-1:0] out_b;
  logic             out_vld;
  logic [LANES-1:0] sat;

  modport master (
    output en, clr, mode, in_a, in_b,
    input  out_a, out_b, out_vld, sat
  );

  modport slave (
    input  en, clr, mode, in_a, in_b,
    output out_a, out_b, out_vld, sat
  );
endinterface

// File: rtl/sc_sync_lane.sv
// One lane: bounded signed save/emit counter that rearranges 1s between streams A and B.
module sc_sync_lane
  import sc_sync_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       zero,
  input  sync_mode_e mode,
  input  logic       a,
  input  logic       b,
  output logic       out_a,
  output logic       out_b,
  output logic       sat
);

  localparam logic signed [CW:0] SMax    = $signed((CW + 1)'(save_max(CW)));
  localparam logic signed [CW:0] SNegMax = -SMax;
  localparam logic signed [CW:0] SZero   = '0;
  localparam logic signed [CW:0] SOne    = {{CW{1'b0}}, 1'b1};

  // s > 0 holds saved A ones, s < 0 holds saved B ones (SKEW: s >= 0 holds saved B ones).
  logic signed [CW:0] s_q, s_cur, s_nxt;
  logic               oa, ob, set_sat;

  always_comb begin
    s_cur   = zero ? SZero : s_q;
    s_nxt   = s_cur;
    oa      = a;
    ob      = b;
    set_sat = 1'b0;
    unique case (mode)
      MODE_SYNC: begin
        if (a && !b) begin
          if (s_cur < SZero) begin
            ob    = 1'b1;
            s_nxt = s_cur + SOne;
          end else if (s_cur < SMax) begin
            oa    = 1'b0;
            s_nxt = s_cur + SOne;
          end else begin
            set_sat = 1'b1;
          end
        end else if (!a && b) begin
          if (s_cur > SZero) begin
            oa    = 1'b1;
            s_nxt = s_cur - SOne;
          end else if (s_cur > SNegMax) begin
            ob    = 1'b0;
            s_nxt = s_cur - SOne;
          end else begin
            set_sat = 1'b1;
          end
        end
      end
      MODE_DESYNC: begin
        if (a && b) begin
          if (s_cur > SNegMax) begin
            ob    = 1'b0;
            s_nxt = s_cur - SOne;
          end else begin
            set_sat = 1'b1;
          end
        end else if (!a && !b && (s_cur < SZero)) begin
          ob    = 1'b1;
          s_nxt = s_cur + SOne;
        end
      end
      MODE_SKEW: begin
        ob = 1'b0;
        if (a && b) begin
          ob = 1'b1;
        end else if (a && !b) begin
          if (s_cur > SZero) begin
            ob    = 1'b1;
            s_nxt = s_cur - SOne;
          end
        end else if (!a && b) begin
          if (s_cur < SMax) begin
            s_nxt = s_cur + SOne;
          end else begin
            ob      = 1'b1;
            set_sat = 1'b1;
          end
        end
      end
      MODE_BYPASS: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= SZero;
      out_a <= 1'b0;
      out_b <= 1'b0;
      sat   <= 1'b0;
    end else begin
      s_q   <= en ? s_nxt : s_cur;
      out_a <= en & oa;
      out_b <= en & ob;
      // A saturation in the clearing cycle is still recorded.
      sat   <= (sat & ~clr) | (en & set_sat);
    end
  end

endmodule

// File: rtl/sc_pair_sync_multi.sv
// Multi-lane correlation manipulator: shared mode tracking plus independent per-lane counters.
module sc_pair_sync_multi
  import sc_sync_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CW    = 4
) (
  input logic               clk,
  input logic               rst,
  sc_pair_sync_multi_if.slave bus
);

  sync_mode_e       mode_q;
  logic             out_vld_q;
  logic             zero;
  logic [LANES-1:0] lane_out_a, lane_out_b, lane_sat;

  // A mode switch drops any saved bits, same as an explicit clear.
  assign zero = bus.clr | (bus.mode != mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_SYNC;
      out_vld_q <= 1'b0;
    end else begin
      mode_q    <= bus.mode;
      out_vld_q <= bus.en;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sc_sync_lane #(
      .CW(CW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.en),
      .clr   (bus.clr),
      .zero  (zero),
      .mode  (bus.mode),
      .a     (bus.in_a[i]),
      .b     (bus.in_b[i]),
      .out_a (lane_out_a[i]),
      .out_b (lane_out_b[i]),
      .sat   (lane_sat[i])
    );
  end

  assign bus.out_a   = lane_out_a;
  assign bus.out_b   = lane_out_b;
  assign bus.sat     = lane_sat;
  assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_sc_pair_sync_multi.sv
// Directed bench for sc_pair_sync_multi with CW=2 (SAVE_MAX=3) and four lanes.
module tb_sc_pair_sync_multi;
  import sc_sync_pkg::*;

  localparam int unsigned LANES = 4;
  localparam logic [3:0] F = 4'hF;
  localparam logic [3:0] Z = 4'h0;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sc_pair_sync_multi_if #(.LANES(LANES)) bus ();

  sc_pair_sync_multi #(
    .LANES(LANES),
    .CW   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one input pair, clock it, then check the registered outputs 1 time unit later.
  task automatic step(input string tag, input logic r, input logic e, input logic c,
                      input sync_mode_e m, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ea, input logic [3:0] eb, input logic ev,
                      input logic [3:0] es);
    rst      = r;
    bus.en   = e;
    bus.clr  = c;
    bus.mode = m;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk);
    #1;
    chk({tag, ".out_a"}, bus.out_a, ea);
    chk({tag, ".out_b"}, bus.out_b, eb);
    chk({tag, ".out_vld"}, {3'b000, bus.out_vld}, {3'b000, ev});
    chk({tag, ".sat"}, bus.sat, es);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;
    bus.mode = MODE_SYNC;
    bus.in_a = Z;
    bus.in_b = Z;
    @(posedge clk);
    #1;

    step("reset", 1, 1, 0, MODE_SYNC, F, Z, Z, Z, 0, Z);

    // SYNC alternating: saved A one pairs with next B one.
    step("sync_alt0", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("sync_alt1", 0, 1, 0, MODE_SYNC, Z, F, F, F, 1, Z);
    step("sync_alt2", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("sync_alt3", 0, 1, 0, MODE_SYNC, Z, F, F, F, 1, Z);

    // SYNC saturation: three A ones saved, then pass-through with sat.
    step("sync_sat0", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("sync_sat1", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("sync_sat2", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("sync_sat3", 0, 1, 0, MODE_SYNC, F, Z, F, Z, 1, F);
    step("sync_sat4", 0, 1, 0, MODE_SYNC, F, Z, F, Z, 1, F);

    step("clr_idle", 0, 0, 1, MODE_SYNC, F, F, Z, Z, 0, Z);

    // DESYNC: split 11 pairs, replay saved B ones into 00 slots, then saturate.
    step("desync0", 0, 1, 0, MODE_DESYNC, F, F, F, Z, 1, Z);
    step("desync1", 0, 1, 0, MODE_DESYNC, F, F, F, Z, 1, Z);
    step("desync2", 0, 1, 0, MODE_DESYNC, Z, Z, Z, F, 1, Z);
    step("desync3", 0, 1, 0, MODE_DESYNC, Z, Z, Z, F, 1, Z);
    step("desync4", 0, 1, 0, MODE_DESYNC, F, F, F, Z, 1, Z);
    step("desync5", 0, 1, 0, MODE_DESYNC, F, F, F, Z, 1, Z);
    step("desync6", 0, 1, 0, MODE_DESYNC, F, F, F, Z, 1, Z);
    step("desync7", 0, 1, 0, MODE_DESYNC, F, F, F, F, 1, F);

    // SKEW with clr in the first cycle: sat cleared, B ones moved under A ones.
    step("skew0", 0, 1, 1, MODE_SKEW, Z, F, Z, Z, 1, Z);
    step("skew1", 0, 1, 0, MODE_SKEW, Z, F, Z, Z, 1, Z);
    step("skew2", 0, 1, 0, MODE_SKEW, F, Z, F, F, 1, Z);
    step("skew3", 0, 1, 0, MODE_SKEW, F, Z, F, F, 1, Z);

    // Mode round trip drops the saved A one.
    step("mchg_save", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("mchg_byp", 0, 1, 0, MODE_BYPASS, F, F, F, F, 1, Z);
    step("mchg_back", 0, 1, 0, MODE_SYNC, Z, F, Z, Z, 1, Z);
    step("mchg_neg", 0, 1, 0, MODE_SYNC, F, Z, F, F, 1, Z);

    // Build s=2 with sat=1, then reset mid-stream.
    step("rst_pre0", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("rst_pre1", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("rst_pre2", 0, 1, 0, MODE_SYNC, F, Z, Z, Z, 1, Z);
    step("rst_pre3", 0, 1, 0, MODE_SYNC, F, Z, F, Z, 1, F);
    step("rst_pre4", 0, 1, 0, MODE_SYNC, Z, F, F, F, 1, F);
    step("rst_mid", 1, 1, 0, MODE_SYNC, Z, F, Z, Z, 0, Z);
    step("rst_post", 0, 1, 0, MODE_SYNC, Z, F, Z, Z, 1, Z);

    // Independent lanes: lane0=10, lane1=01, lane2=11, lane3=00; then hold with en=0.
    step("lanes_clr", 0, 0, 1, MODE_SYNC, Z, Z, Z, Z, 0, Z);
    step("lanes0", 0, 1, 0, MODE_SYNC, 4'b0101, 4'b0110, 4'b0100, 4'b0100, 1, Z);
    step("lanes_hold", 0, 0, 0, MODE_SYNC, 4'b1010, 4'b1001, Z, Z, 0, Z);
    step("lanes1", 0, 1, 0, MODE_SYNC, 4'b1010, 4'b1001, 4'b1011, 4'b1011, 1, Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
